instr_feeder: RTL and testbench

- Instruction-stream source for the `top` processor: drives its `din` and `run` inputs and watches its `done` output.
- Holds a small program RAM loaded through a write port.
- On `start`, it walks the program and presents each instruction word, plus the immediate word for MVI, in step with the processor's t0/t1..t3 sequencing.
- It advances only on `done`, and it stops at the end of the program or on a watchdog timeout.

---
 rtl/proc_pkg.sv | 21 ++
 rtl/prog_ram.sv | 17 +
 rtl/instr_feeder.sv | 90 +++++++++
 tb/tb_instr_feeder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, instruction field helpers and feeder state encoding shared with the processor.
package proc_pkg;
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam int INSTR_W = 9;
  localparam int OP_LSB = 6;
  localparam int RX_LSB = 3;
  localparam int RY_LSB = 0;
  typedef enum logic [2:0] {IDLE, FETCH, IMM, WAIT, END} feeder_state_t;
  function automatic logic [2:0] op_f(input logic [INSTR_W-1:0] ir);
    return ir[OP_LSB+:3];
  endfunction
  function automatic logic [2:0] rx_f(input logic [INSTR_W-1:0] ir);
    return ir[RX_LSB+:3];
  endfunction
  function automatic logic [2:0] ry_f(input logic [INSTR_W-1:0] ir);
    return ir[RY_LSB+:3];
  endfunction
endpackage

// File: rtl/prog_ram.sv
// prog_ram: program store with synchronous write and asynchronous read.
module prog_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [REG_WIDTH-1:0]  wd,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [REG_WIDTH-1:0]  rd
);
  logic [REG_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: walks a loaded program and feeds instruction/immediate words to the processor, paced by done.
module instr_feeder
  import proc_pkg::*;
#(
  parameter int REG_WIDTH         = 16,
  parameter int INSTRUCTION_WIDTH = 9,
  parameter int ADDR_WIDTH        = 5,
  parameter int TIMEOUT           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_WIDTH-1:0]  wr_data,
  input  logic                  done,
  output logic [REG_WIDTH-1:0]  din,
  output logic                  run,
  output logic                  busy,
  output logic                  finished,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   instr_count
);
  localparam int WW = $clog2(TIMEOUT + 1);
  feeder_state_t state;
  logic [ADDR_WIDTH:0] pc, pc_inc;
  logic [WW-1:0] wdog;
  logic [REG_WIDTH-1:0] rd, iw;
  logic pc_ok, more;
  prog_ram #(.ADDR_WIDTH(ADDR_WIDTH), .REG_WIDTH(REG_WIDTH)) u_ram (
    .clk(clk),
    .we (wr_en && !busy),
    .wa (wr_addr),
    .wd (wr_data),
    .ra (pc[ADDR_WIDTH-1:0]),
    .rd (rd)
  );
  assign busy   = state == FETCH || state == IMM || state == WAIT;
  assign run    = busy;
  assign pc_inc = pc + 1'b1;
  assign pc_ok  = pc < prog_len;
  // IMM consumes its immediate word on done, so the next fetch is one word further on
  assign more   = state == IMM ? pc_inc < prog_len : pc_ok;
  assign din    = state == FETCH ? rd :
                  state == WAIT ? iw :
                  state == IMM && pc_ok ? rd : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      wdog        <= '0;
      iw          <= '0;
      finished    <= 1'b0;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE, END: if (start) begin
          if (prog_len != '0) begin
            pc          <= '0;
            instr_count <= '0;
            finished    <= 1'b0;
            err         <= 1'b0;
            state       <= FETCH;
          end else finished <= 1'b1;
        end
        FETCH: begin
          pc    <= pc_inc;
          wdog  <= '0;
          iw    <= rd;
          state <= op_f(rd[INSTRUCTION_WIDTH-1:0]) == OP_MVI ? IMM : WAIT;
        end
        IMM, WAIT: begin
          if (state == IMM && !pc_ok) err <= 1'b1;
          if (done) begin
            if (~&instr_count) instr_count <= instr_count + 1'b1;
            if (state == IMM) pc <= pc_inc;
            state    <= more ? FETCH : END;
            finished <= !more;
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            finished <= 1'b1;
            state    <= END;
          end else wdog <= wdog + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: random and directed programs run through a small processor model, checked against a program-level reference.
module tb_instr_feeder;
  import proc_pkg::*;
  localparam int RW = 16;
  localparam int AW = 5;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, wr_en = 1'b0, done;
  logic [AW:0] prog_len = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [RW-1:0] wr_data = '0, din;
  logic run, busy, finished, err;
  logic [AW:0] instr_count;
  int errors = 0, checks = 0;

  instr_feeder #(.REG_WIDTH(RW), .INSTRUCTION_WIDTH(9), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .din(din), .run(run),
    .busy(busy), .finished(finished), .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] alu(input logic [2:0] op, input logic [RW-1:0] a, b, imm);
    return op == OP_MV ? b : op == OP_MVI ? imm : op == OP_ADD ? a + b : op == OP_SUB ? a - b : '0;
  endfunction

  // processor model: latches IR in t0, raises done after its step latency plus a random stretch
  logic [RW-1:0] r [8];
  logic [8:0] ir;
  logic active, stall = 1'b0;
  int cyc, lat;
  logic [RW-1:0] bus_log [$];
  assign done = active && !stall && cyc >= lat;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      active <= 1'b0;
      cyc <= 0;
      lat <= 1;
      ir <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else if (!active) begin
      if (run) begin
        ir <= din[8:0];
        active <= 1'b1;
        cyc <= 1;
        lat <= ((din[8:6] == OP_ADD || din[8:6] == OP_SUB) ? 3 : 1) + int'($urandom_range(0, 2));
      end
    end else if (done) begin
      active <= 1'b0;
      if (op_f(ir) <= OP_SUB) r[rx_f(ir)] <= alu(op_f(ir), r[rx_f(ir)], r[ry_f(ir)], din);
      bus_log.push_back(alu(op_f(ir), r[rx_f(ir)], r[ry_f(ir)], din));
    end else cyc <= cyc + 1;

  logic [RW-1:0] prog [32];
  logic [RW-1:0] ref_r [8];
  logic [RW-1:0] ref_bus [$];
  int ref_cnt;
  logic ref_err;

  task automatic ref_run(input int len);
    int pc;
    logic [RW-1:0] w, imm, b;
    pc = 0;
    ref_cnt = 0;
    ref_err = 1'b0;
    ref_bus.delete();
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    while (pc < len) begin
      w = prog[pc];
      pc++;
      imm = '0;
      if (w[8:6] == OP_MVI) begin
        if (pc < len) imm = prog[pc];
        else ref_err = 1'b1;
        pc++;
      end
      b = alu(w[8:6], ref_r[w[5:3]], ref_r[w[2:0]], imm);
      if (w[8:6] <= OP_SUB) ref_r[w[5:3]] = b;
      ref_bus.push_back(b);
      ref_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic load(input int from, input int len);
    for (int i = from; i < len; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = AW'(i);
      wr_data = prog[i];
    end
    @(negedge clk) wr_en = 1'b0;
  endtask

  // mode 0: plain run; 1: start and RAM write pulsed while busy; 2: word 0 written in the start cycle
  task automatic go(input string n, input int len, input int mode);
    int k;
    ref_run(len);
    bus_log.delete();
    prog_len = (AW+1)'(len);
    @(negedge clk);
    start = 1'b1;
    if (mode == 2) begin wr_en = 1'b1; wr_addr = '0; wr_data = prog[0]; end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    if (mode == 1) begin
      start = 1'b1;
      wr_en = 1'b1;
      wr_addr = 2;
      wr_data = ~prog[2];
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
    end
    k = 0;
    while (!finished && k < 500) begin @(negedge clk); k++; end
    check({n, ".finished"}, finished, 1);
    check({n, ".busy"}, busy, 0);
    check({n, ".run"}, run, 0);
    check({n, ".din"}, din, 0);
    check({n, ".err"}, err, ref_err);
    check({n, ".count"}, instr_count, ref_cnt);
    check({n, ".nbus"}, bus_log.size(), ref_bus.size());
    for (int i = 0; i < ref_bus.size() && i < bus_log.size(); i++)
      check($sformatf("%s.bus%0d", n, i), bus_log[i], ref_bus[i]);
    for (int i = 0; i < 8; i++) check($sformatf("%s.r%0d", n, i), r[i], ref_r[i]);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, len;
    logic [RW-1:0] w;
    repeat (2) @(negedge clk);
    check("rst.din", din, 0);
    check("rst.run", run, 0);
    check("rst.busy", busy, 0);
    check("rst.finished", finished, 0);
    check("rst.err", err, 0);
    check("rst.count", instr_count, 0);
    rst = 1'b1;
    // empty program: only finished rises
    prog_len = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    check("empty.finished", finished, 1);
    check("empty.busy", busy, 0);
    check("empty.count", instr_count, 0);
    // MVI R0,5 ; MV R1,R0
    prog[0] = 16'h0040; prog[1] = 16'h0005; prog[2] = 16'h0008;
    do_reset();
    load(0, 3);
    go("t1", 3, 0);
    check("t1.bus_mvi", bus_log[0], 16'h0005);
    check("t1.bus_mv", bus_log[1], 16'h0005);
    check("t1.r0", r[0], 16'h0005);
    check("t1.r1", r[1], 16'h0005);
    check("t1.count_abs", instr_count, 2);
    // MVI R4,5 ; MVI R5,3 ; ADD R4,R5 ; SUB R4,R5
    prog[0] = 16'h0060; prog[1] = 16'h0005; prog[2] = 16'h0068;
    prog[3] = 16'h0003; prog[4] = 16'h00A5; prog[5] = 16'h00E5;
    do_reset();
    load(0, 6);
    go("t2", 6, 0);
    check("t2.bus_add", bus_log[2], 16'h0008);
    check("t2.bus_sub", bus_log[3], 16'h0005);
    check("t2.count_abs", instr_count, 4);
    // reset while presenting the first immediate
    do_reset();
    prog_len = 6;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    check("mid.imm_din", din, 16'h0005);
    check("mid.busy", busy, 1);
    rst = 1'b0;
    #1;
    check("mid.rst_din", din, 0);
    check("mid.rst_run", run, 0);
    check("mid.rst_busy", busy, 0);
    check("mid.rst_count", instr_count, 0);
    @(negedge clk) rst = 1'b1;
    go("t2_restart", 6, 0);
    // disturbances while busy, then an undisturbed rerun proves word 2 survived
    do_reset();
    go("t2_disturb", 6, 1);
    do_reset();
    go("t2_after", 6, 0);
    // MVI with no immediate word
    prog[0] = 16'h0040;
    do_reset();
    load(0, 1);
    go("trunc", 1, 0);
    check("trunc.err_abs", err, 1);
    check("trunc.imm_zero", bus_log[0], 0);
    // stalled processor: FETCH plus TIMEOUT cycles of WAIT
    prog[0] = 16'h0008;
    do_reset();
    load(0, 1);
    stall = 1'b1;
    prog_len = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    check("wd.busy_cycles", n, 1 + TO);
    check("wd.err", err, 1);
    check("wd.run", run, 0);
    check("wd.busy", busy, 0);
    check("wd.finished", finished, 1);
    check("wd.count", instr_count, 0);
    stall = 1'b0;
    // random programs
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        w = RW'($urandom);
        if ($urandom_range(0, 7) != 0) w[8:6] = 3'($urandom_range(0, 3));
        prog[i] = w;
      end
      do_reset();
      load(t % 3 == 2 ? 1 : 0, len);
      go($sformatf("rnd%0d", t), len, t % 3);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
